// File: rtl/whh_grad_update.sv
// Whh gradient accumulator and 4x4 recurrent-weight register file for the GRU backward path.
// Gradients are summed per weight over a batch; at batch end each weight is stepped by -acc/2^LR_SHIFT.
module whh_grad_update #(
    parameter int DATABIT  = 16,
    parameter int CELLNUM  = 4,
    parameter int HTNUM    = 64,
    parameter int ACCBIT   = 24,
    parameter int LR_SHIFT = 6,
    parameter int BATCH    = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   grad_valid,
    input  logic [DATABIT-1:0]                     grad,
    output logic                                   grad_ready,
    input  logic                                   flush,
    input  logic                                   wr_en,
    input  logic [$clog2(CELLNUM*CELLNUM)-1:0]     wr_addr,
    input  logic [DATABIT-1:0]                     wr_data,
    input  logic [$clog2(CELLNUM)-1:0]             rd_row,
    output logic [HTNUM-1:0]                       whh_row,
    output logic                                   update_done,
    output logic                                   busy,
    output logic                                   err_drop
);

    localparam int unsigned NW = CELLNUM * CELLNUM;
    localparam int unsigned IW = $clog2(NW);
    localparam int unsigned RW = $clog2(CELLNUM);
    localparam logic [3:0]  BATCH_W = 4'(BATCH);
    localparam logic signed [ACCBIT:0] W_MAX = {{(ACCBIT-DATABIT+2){1'b0}}, {(DATABIT-1){1'b1}}};
    localparam logic signed [ACCBIT:0] W_MIN = {{(ACCBIT-DATABIT+2){1'b1}}, {(DATABIT-1){1'b0}}};

    typedef enum logic [1:0] {ACCUM, UPDATE, DONE} state_t;

    state_t                     state_q;
    logic signed [DATABIT-1:0]  w_q   [NW];
    logic signed [ACCBIT-1:0]   acc_q [NW];
    logic [IW-1:0]              idx_q;
    logic [IW-1:0]              uidx_q;
    logic [3:0]                 samp_q;
    logic [HTNUM-1:0]           whh_row_q;
    logic                       update_done_q;
    logic                       err_drop_q;

    logic signed [ACCBIT:0]     acc_sum;
    logic signed [ACCBIT-1:0]   acc_d;
    logic signed [ACCBIT-1:0]   step;
    logic signed [ACCBIT:0]     w_diff;
    logic signed [DATABIT-1:0]  w_d;
    logic [HTNUM-1:0]           row_d;
    logic [3:0]                 samp_inc;
    logic                       accept;
    logic                       flush_ok;
    logic                       sample_end;

    always_comb begin
        accept     = (state_q == ACCUM) && grad_valid;
        flush_ok   = (state_q == ACCUM) && flush && !grad_valid && (idx_q == '0) && (samp_q != '0);
        sample_end = accept && (idx_q == IW'(NW - 1));
        samp_inc   = samp_q + 4'd1;

        // Sum one bit wider than the accumulator; a sign/carry disagreement means overflow.
        acc_sum = {acc_q[idx_q][ACCBIT-1], acc_q[idx_q]}
                + {{(ACCBIT+1-DATABIT){grad[DATABIT-1]}}, grad};
        if (acc_sum[ACCBIT] != acc_sum[ACCBIT-1]) begin
            acc_d = acc_sum[ACCBIT] ? {1'b1, {(ACCBIT-1){1'b0}}} : {1'b0, {(ACCBIT-1){1'b1}}};
        end else begin
            acc_d = acc_sum[ACCBIT-1:0];
        end

        step   = acc_q[uidx_q] >>> LR_SHIFT;
        w_diff = {{(ACCBIT+1-DATABIT){w_q[uidx_q][DATABIT-1]}}, w_q[uidx_q]}
               - {step[ACCBIT-1], step};
        if (w_diff > W_MAX) begin
            w_d = W_MAX[DATABIT-1:0];
        end else if (w_diff < W_MIN) begin
            w_d = W_MIN[DATABIT-1:0];
        end else begin
            w_d = w_diff[DATABIT-1:0];
        end

        row_d = '0;
        for (int unsigned c = 0; c < CELLNUM; c++) begin
            row_d[c*DATABIT +: DATABIT] = w_q[{rd_row, RW'(c)}];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ACCUM;
            idx_q         <= '0;
            uidx_q        <= '0;
            samp_q        <= '0;
            whh_row_q     <= '0;
            update_done_q <= 1'b0;
            err_drop_q    <= 1'b0;
            for (int unsigned i = 0; i < NW; i++) begin
                w_q[i]   <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            update_done_q <= 1'b0;
            whh_row_q     <= row_d;
            if (grad_valid && (state_q != ACCUM)) begin
                err_drop_q <= 1'b1;
            end
            case (state_q)
                ACCUM: begin
                    if (wr_en) begin
                        w_q[wr_addr] <= wr_data;
                    end
                    if (accept) begin
                        acc_q[idx_q] <= acc_d;
                        idx_q        <= idx_q + 1'b1;
                        if (sample_end) begin
                            samp_q <= samp_inc;
                            if (samp_inc == BATCH_W) begin
                                state_q <= UPDATE;
                                uidx_q  <= '0;
                            end
                        end
                    end else if (flush_ok) begin
                        state_q <= UPDATE;
                        uidx_q  <= '0;
                    end
                end
                UPDATE: begin
                    w_q[uidx_q]   <= w_d;
                    acc_q[uidx_q] <= '0;
                    uidx_q        <= uidx_q + 1'b1;
                    if (uidx_q == IW'(NW - 1)) begin
                        state_q       <= DONE;
                        update_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    samp_q  <= '0;
                    idx_q   <= '0;
                    state_q <= ACCUM;
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign grad_ready  = (state_q == ACCUM);
    assign busy        = (state_q != ACCUM);
    assign whh_row     = whh_row_q;
    assign update_done = update_done_q;
    assign err_drop    = err_drop_q;

endmodule

// File: tb/tb_whh_grad_update.sv
// Bench for whh_grad_update: directed vector table, multi-cycle corner sequences,
// and randomized batches checked against a batch-level arithmetic model.
module tb_whh_grad_update;

    logic        clk = 1'b0;
    logic        rst;
    logic        grad_valid;
    logic [15:0] grad;
    logic        grad_ready;
    logic        flush;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  rd_row;
    logic [63:0] whh_row;
    logic        update_done;
    logic        busy;
    logic        err_drop;

    always #5 clk = ~clk;

    whh_grad_update #(
        .DATABIT(16), .CELLNUM(4), .HTNUM(64), .ACCBIT(24), .LR_SHIFT(6), .BATCH(2)
    ) dut (
        .clk(clk), .rst(rst), .grad_valid(grad_valid), .grad(grad), .grad_ready(grad_ready),
        .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_row(rd_row),
        .whh_row(whh_row), .update_done(update_done), .busy(busy), .err_drop(err_drop)
    );

    typedef struct {
        int unsigned index;
        logic [15:0] w0;
        logic [15:0] g;
        logic [15:0] expw;
    } vec_t;

    vec_t        vecs [6];
    logic [15:0] gvec [2][16];
    int          mw   [16];
    int          macc [16];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_w(input int unsigned a, input logic [15:0] d);
        wr_addr = 4'(a);
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic read_row(input int unsigned r, output logic [63:0] v);
        rd_row = 2'(r);
        tick();
        v = whh_row;
    endtask

    task automatic send_word(input logic [15:0] g);
        grad_valid = 1'b1;
        grad       = g;
        tick();
        grad_valid = 1'b0;
    endtask

    task automatic send_batch(input int nsamp, input bit gaps);
        for (int s = 0; s < nsamp; s++) begin
            for (int k = 0; k < 16; k++) begin
                if (gaps && $urandom_range(0, 3) == 0) tick();
                send_word(gvec[s][k]);
            end
        end
    endtask

    // Called right after the cycle holding the last word/flush; returns its cycle distance to update_done.
    task automatic wait_done(output int n);
        n = 1;
        while (!update_done && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic zero_gvec();
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 16; k++) gvec[s][k] = 16'h0000;
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] row;
        logic [63:0] erow;
        int          n;
        int          cnt;
        bit          saw;

        vecs[0] = '{0,  16'h4000, 16'h0400, 16'h3FE0};
        vecs[1] = '{5,  16'h7FF0, 16'hF800, 16'h7FFF};
        vecs[2] = '{10, 16'h8010, 16'h0800, 16'h8000};
        vecs[3] = '{15, 16'h0000, 16'hFFFF, 16'h0001};
        vecs[4] = '{3,  16'h1234, 16'h003F, 16'h1233};
        vecs[5] = '{7,  16'h0100, 16'h7FFF, 16'hFD01};

        rst = 1'b1; grad_valid = 1'b1; grad = 16'h1234; flush = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_row = '0;
        tick();
        tick();
        rst = 1'b0; grad_valid = 1'b0;
        chk("reset_whh_row", whh_row, 64'h0);
        chk("reset_grad_ready", 64'(grad_ready), 64'h1);
        chk("reset_update_done", 64'(update_done), 64'h0);
        chk("reset_err_drop", 64'(err_drop), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);

        for (int v = 0; v < 6; v++) begin
            wr_w(vecs[v].index, vecs[v].w0);
            zero_gvec();
            gvec[0][vecs[v].index] = vecs[v].g;
            gvec[1][vecs[v].index] = vecs[v].g;
            send_batch(2, 1'b0);
            wait_done(n);
            chk($sformatf("vec%0d_done_latency", v), 64'(n), 64'd17);
            tick();
            chk($sformatf("vec%0d_ready_again", v), 64'(grad_ready), 64'h1);
            read_row(vecs[v].index / 4, row);
            chk($sformatf("vec%0d_weight", v), 64'(row[(vecs[v].index % 4)*16 +: 16]), 64'(vecs[v].expw));
            if (v == 0) chk("vec0_full_row", row, 64'h0000_0000_0000_3FE0);
        end
        chk("no_drop_yet", 64'(err_drop), 64'h0);

        // Backpressure: keep offering words through UPDATE/DONE; none may land.
        wr_w(2, 16'h0100);
        zero_gvec();
        send_batch(2, 1'b0);
        grad_valid = 1'b1;
        grad       = 16'h7000;
        cnt        = 0;
        while (!grad_ready && cnt < 40) begin
            cnt++;
            tick();
        end
        grad_valid = 1'b0;
        chk("bp_not_ready_cycles", 64'(cnt), 64'd17);
        chk("bp_err_drop_set", 64'(err_drop), 64'h1);
        gvec[0][2] = 16'h0200;
        gvec[1][2] = 16'h0200;
        send_batch(2, 1'b0);
        wait_done(n);
        chk("bp_next_latency", 64'(n), 64'd17);
        tick();
        read_row(0, row);
        chk("bp_next_batch_row0", row, 64'h1233_00F0_0000_3FE0);
        chk("bp_err_drop_sticky", 64'(err_drop), 64'h1);

        // Flush: ignored with no sample and mid-sample, accepted at a sample boundary.
        wr_w(15, 16'h0000);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_samp0_ignored", 64'(busy), 64'h0);
        for (int k = 0; k < 3; k++) send_word(16'h0000);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_idx3_ignored", 64'(busy), 64'h0);
        for (int k = 3; k < 16; k++) send_word(k == 15 ? 16'h0040 : 16'h0000);
        flush = 1'b1; tick(); flush = 1'b0;
        wait_done(n);
        chk("flush_latency", 64'(n), 64'd17);
        tick();
        read_row(3, row);
        chk("flush_w15", 64'(row[63:48]), 64'hFFFF);

        // Reset in the middle of an update.
        zero_gvec();
        gvec[0][0] = 16'h0100;
        send_batch(2, 1'b0);
        for (int c = 1; c < 8; c++) tick();
        chk("midrst_busy_before", 64'(busy), 64'h1);
        rst = 1'b1; tick(); rst = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (update_done) saw = 1'b1;
            tick();
        end
        chk("midrst_no_done", 64'(saw), 64'h0);
        chk("midrst_ready", 64'(grad_ready), 64'h1);
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_err_drop_cleared", 64'(err_drop), 64'h0);
        for (int r = 0; r < 4; r++) begin
            read_row(r, row);
            chk($sformatf("midrst_row%0d", r), row, 64'h0);
        end

        // Randomized batches against the arithmetic model.
        for (int i = 0; i < 16; i++) mw[i] = 0;
        for (int it = 0; it < 6; it++) begin
            int nsamp;
            nsamp = (it % 2 == 1) ? 1 : 2;
            for (int i = 0; i < 16; i++) begin
                logic [15:0] d;
                d = rnd16();
                wr_w(i, d);
                mw[i] = int'($signed(d));
                macc[i] = 0;
            end
            for (int s = 0; s < nsamp; s++) begin
                for (int k = 0; k < 16; k++) begin
                    gvec[s][k] = rnd16();
                    macc[k] += int'($signed(gvec[s][k]));
                    if (macc[k] > 8388607) macc[k] = 8388607;
                    if (macc[k] < -8388608) macc[k] = -8388608;
                end
            end
            send_batch(nsamp, 1'b1);
            if (nsamp == 1) begin
                flush = 1'b1; tick(); flush = 1'b0;
            end
            wait_done(n);
            chk($sformatf("rnd%0d_latency", it), 64'(n), 64'd17);
            for (int i = 0; i < 16; i++) mw[i] = clamp16(mw[i] - (macc[i] >>> 6));
            tick();
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) erow[c*16 +: 16] = 16'(mw[r*4 + c]);
                read_row(r, row);
                chk($sformatf("rnd%0d_row%0d", it, r), row, erow);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
